// File: rtl/vend_core_if.sv
// Switch word in, status LEDs and eight 7-segment digits out, grouped as one bus.
// Latency: none (plain wires).
// Backpressure: none; the switch word is a level sampled every cycle.
// Ports: sw (18b switch word), ledg (8b status), hex0..hex7 (7b active-low gfedcba).
interface vend_core_if;
    logic [17:0] sw;
    logic [7:0]  ledg;
    logic [6:0]  hex0;
    logic [6:0]  hex1;
    logic [6:0]  hex2;
    logic [6:0]  hex3;
    logic [6:0]  hex4;
    logic [6:0]  hex5;
    logic [6:0]  hex6;
    logic [6:0]  hex7;

    // master: whoever owns the switch register and watches the board outputs
    modport master (
        output sw,
        input  ledg, hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7
    );

    // slave: the vending core itself
    modport slave (
        input  sw,
        output ledg, hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7
    );
endinterface

// File: rtl/vend_core.sv
// Vending core: switch edges -> coin/purchase/cancel events, credit tracking, dispense/change sequencing.
// Latency: an event at edge k updates state at edge k; ledg/hex reflect it at edge k+1.
// Backpressure: none; events arriving outside IDLE are rejected (coins) or dropped (purchase/cancel).
// Ports: clk, reset (sync, active-high), bus.sw in, bus.ledg / bus.hex0..hex7 out (registered).
module vend_core #(
    parameter int PRICE0      = 5,
    parameter int PRICE1      = 10,
    parameter int PRICE2      = 15,
    parameter int PRICE3      = 25,
    parameter int MAX_CREDIT  = 99,
    parameter int DISP_CYCLES = 50000000,
    parameter int CHG_CYCLES  = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    vend_core_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPENSE = 2'd1,
        S_CHANGE   = 2'd2
    } state_t;

    localparam logic [31:0] DISP_LOAD = 32'(DISP_CYCLES - 1);
    localparam logic [31:0] CHG_LOAD  = 32'(CHG_CYCLES - 1);
    localparam logic [7:0]  MAX_SUM   = 8'(MAX_CREDIT);
    localparam logic [6:0]  SEG_BLANK = 7'h7F;

    state_t      r_state, w_state_nxt;
    logic [17:0] r_sw_q;
    logic [6:0]  r_credit, w_credit_nxt;
    logic [6:0]  r_change, w_change_nxt;
    logic [6:0]  r_sold,   w_sold_nxt;
    logic [31:0] r_timer,  w_timer_nxt;
    logic        r_reject, w_reject_nxt;
    logic        r_insuf,  w_insuf_nxt;

    logic [7:0]       r_ledg, w_ledg;
    logic [7:0][6:0]  r_hex,  w_hex;

    logic [6:0]  w_ev;
    logic        w_any_coin;
    logic [7:0]  w_coin_sum;
    logic [7:0]  w_credit_sum;
    logic [6:0]  w_price;
    logic        w_unused_sw;

    function automatic logic [6:0] price_of(input logic [1:0] sel);
        logic [6:0] p;
        case (sel)
            2'd0:    p = 7'(PRICE0);
            2'd1:    p = 7'(PRICE1);
            2'd2:    p = 7'(PRICE2);
            default: p = 7'(PRICE3);
        endcase
        return p;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] tens(input logic [6:0] v);
        return seg7(4'(v / 7'd10));
    endfunction

    function automatic logic [6:0] units(input logic [6:0] v);
        return seg7(4'(v % 7'd10));
    endfunction

    // Only the low seven switch bits carry meaning.
    assign w_unused_sw  = &{1'b0, bus.sw[17:7], r_sw_q[17:7]};

    assign w_ev         = bus.sw[6:0] & ~r_sw_q[6:0];
    assign w_any_coin   = |w_ev[2:0];
    assign w_coin_sum   = {7'd0, w_ev[0]} + (w_ev[1] ? 8'd5 : 8'd0) + (w_ev[2] ? 8'd10 : 8'd0);
    assign w_credit_sum = {1'b0, r_credit} + w_coin_sum;
    assign w_price      = price_of(bus.sw[4:3]);

    // Next-state logic
    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_change_nxt = r_change;
        w_sold_nxt   = r_sold;
        w_timer_nxt  = r_timer;
        w_reject_nxt = r_reject;
        w_insuf_nxt  = r_insuf;

        case (r_state)
            S_IDLE: begin
                if (w_ev[6]) begin
                    // Cancel wins over everything else in the same cycle.
                    w_change_nxt = r_credit;
                    w_credit_nxt = 7'd0;
                    w_timer_nxt  = CHG_LOAD;
                    w_reject_nxt = 1'b0;
                    w_state_nxt  = S_CHANGE;
                end else if (w_ev[5] && (r_credit >= w_price)) begin
                    w_change_nxt = r_credit - w_price;
                    w_credit_nxt = 7'd0;
                    w_sold_nxt   = (r_sold == 7'd99) ? 7'd0 : r_sold + 7'd1;
                    w_timer_nxt  = DISP_LOAD;
                    w_insuf_nxt  = 1'b0;
                    // Coins landing with a successful purchase are bounced.
                    w_reject_nxt = w_any_coin;
                    w_state_nxt  = S_DISPENSE;
                end else begin
                    if (w_any_coin) begin
                        if (w_credit_sum <= MAX_SUM) begin
                            w_credit_nxt = w_credit_sum[6:0];
                            w_reject_nxt = 1'b0;
                            w_insuf_nxt  = 1'b0;
                        end else begin
                            w_reject_nxt = 1'b1;
                        end
                    end
                    // A failed purchase is judged on the pre-coin credit and its
                    // flag survives an accepted coin in the same cycle.
                    if (w_ev[5]) begin
                        w_insuf_nxt = 1'b1;
                    end
                end
            end

            S_DISPENSE: begin
                if (w_any_coin) begin
                    w_reject_nxt = 1'b1;
                end
                if (r_timer == 32'd0) begin
                    if (r_change != 7'd0) begin
                        w_timer_nxt = CHG_LOAD;
                        w_state_nxt = S_CHANGE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_timer_nxt = r_timer - 32'd1;
                end
            end

            S_CHANGE: begin
                if (w_any_coin) begin
                    w_reject_nxt = 1'b1;
                end
                if (r_timer == 32'd0) begin
                    w_change_nxt = 7'd0;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer - 32'd1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Board outputs, computed from the registered state
    always_comb begin
        w_ledg = {r_reject, r_insuf, bus.sw[4:3], (r_state == S_IDLE),
                  (r_credit >= w_price), (r_state == S_CHANGE), (r_state == S_DISPENSE)};
        w_hex    = '1;
        w_hex[0] = units(r_credit);
        w_hex[1] = tens(r_credit);
        w_hex[2] = units(w_price);
        w_hex[3] = tens(w_price);
        w_hex[4] = (r_state == S_CHANGE) ? units(r_change) : SEG_BLANK;
        w_hex[5] = (r_state == S_CHANGE) ? tens(r_change)  : SEG_BLANK;
        w_hex[6] = units(r_sold);
        w_hex[7] = tens(r_sold);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            // All ones so that switches already high at release raise no event.
            r_sw_q   <= '1;
            r_credit <= 7'd0;
            r_change <= 7'd0;
            r_sold   <= 7'd0;
            r_timer  <= 32'd0;
            r_reject <= 1'b0;
            r_insuf  <= 1'b0;
            r_ledg   <= 8'b0000_1000;
            r_hex    <= {8{7'h40}};
        end else begin
            r_state  <= w_state_nxt;
            r_sw_q   <= bus.sw;
            r_credit <= w_credit_nxt;
            r_change <= w_change_nxt;
            r_sold   <= w_sold_nxt;
            r_timer  <= w_timer_nxt;
            r_reject <= w_reject_nxt;
            r_insuf  <= w_insuf_nxt;
            r_ledg   <= w_ledg;
            r_hex    <= w_hex;
        end
    end

    assign bus.ledg = r_ledg;
    assign bus.hex0 = r_hex[0];
    assign bus.hex1 = r_hex[1];
    assign bus.hex2 = r_hex[2];
    assign bus.hex3 = r_hex[3];
    assign bus.hex4 = r_hex[4];
    assign bus.hex5 = r_hex[5];
    assign bus.hex6 = r_hex[6];
    assign bus.hex7 = r_hex[7];

endmodule

// File: doc/vend_core.md
Name: vend_core

Overview:
- Vending-machine core that consumes the 18-bit switch word written by the CPU through the Avalon slave wrapper. It sits directly downstream of that register.
- Turns level changes on the switch bits into coin, purchase and cancel events, and tracks credit.
- Sequences dispense and change phases.
- Drives the eight active-low 7-segment digits and the green LEDs on the DE2 board.

Parameters:
- PRICE0, 5, price of item 0 in credit units
- PRICE1, 10, price of item 1
- PRICE2, 15, price of item 2
- PRICE3, 25, price of item 3
- MAX_CREDIT, 99, credit ceiling (must be <= 99)
- DISP_CYCLES, 50000000, clocks the dispense phase lasts (>= 1)
- CHG_CYCLES, 50000000, clocks the change phase lasts (>= 1)

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- sw  in  18  switch word from the Avalon register. [0] coin 1, [1] coin 5, [2] coin 10, [4:3] item select, [5] purchase, [6] cancel, [17:7] ignored
- ledg  out  8  status. [0] dispensing, [1] returning change, [2] affordable, [3] idle, [5:4] selected item, [6] insufficient, [7] coin rejected
- hex0..hex7  out  7 each  active-low segments, gfedcba. HEX1:HEX0 credit, HEX3:HEX2 selected price, HEX5:HEX4 change, HEX7:HEX6 items sold (mod 100)

Behaviour:
- Single clock domain; one clock, reset is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - credit, change and sold count = 0; FSM = IDLE.
  - sw_q (previous-sample register) = all ones, so bits already high at reset release generate no event.
  - ledg = 8'b0000_1000 plus the selected item from the next cycle.
  - hex0..hex7 = 7'h40 (digit 0).
- Event detection: event[i] = sw[i] & ~sw_q[i]; sw_q <= sw every cycle. An event seen at edge k updates internal state at edge k. hex and ledg are registered and reflect that update at edge k+1.
- FSM states IDLE, DISPENSE, CHANGE:
  - IDLE with cancel event: change <= credit; credit <= 0; timer <= CHG_CYCLES-1; go to CHANGE. Cancel beats purchase and coins in the same cycle; those are discarded.
  - IDLE with purchase event and credit >= price(sel): change <= credit-price; credit <= 0; sold <= (sold+1) mod 100; timer <= DISP_CYCLES-1; go to DISPENSE; clear insufficient. Coin events in the same cycle are rejected.
  - IDLE with purchase event and credit < price(sel): set insufficient; stay in IDLE; credit unchanged. Coins in the same cycle are still processed.
  - IDLE with coin events: sum = 1*ev0 + 5*ev1 + 10*ev2 (all simultaneous coins combined).
    - If credit+sum <= MAX_CREDIT: credit += sum; clear reject and insufficient.
    - Otherwise reject the whole sum: credit unchanged; set reject.
  - DISPENSE: timer counts down; at 0 go to CHANGE with timer <= CHG_CYCLES-1 if change > 0, otherwise go to IDLE.
  - CHANGE: timer counts down; at 0 set change <= 0 and go to IDLE.
  - Any coin event outside IDLE sets reject and is discarded. Purchase and cancel events outside IDLE are ignored.
- Flag lifetimes:
  - reject stays set until the next accepted coin, or until leaving IDLE via purchase or cancel.
  - insufficient stays set until an accepted coin or a successful purchase.
- ledg bits:
  - [2] = credit >= price(sel), combinational on registered values, then registered.
  - [3] = state==IDLE.
  - [5:4] = sw[4:3] registered.
- Displays:
  - Each 2-digit value is split into tens and units (values are always <= 99) and decoded with the standard 0-9 active-low table.
  - HEX5:HEX4 show blank (7'h7F) when state is not CHANGE.
  - Other digits never blank; leading zero is shown.
- Arithmetic: credit, change and sold are 7-bit unsigned. Internal sums use 8 bits, so no wrap occurs before the ceiling compare.
- Reset mid-operation: abandons dispense or change immediately; any pending change is lost; all values return to reset values on the next edge.

Test Plan:
- Reset with sw[1]=1 held, release reset, keep sw constant -> credit stays 0; HEX0=7'h40.
- Toggle sw[2] 0->1 twice (via 0) and sw[1] once -> credit 25; HEX1=7'h24 ("2"), HEX0=7'h12 ("5"); ledg[2]=1 with sel=3.
- Credit 25, sel=1, rising sw[5], DISP_CYCLES=4, CHG_CYCLES=3 -> ledg[0] high 4 cycles, then ledg[1] high 3 cycles with HEX5:HEX4 showing "15"; back to IDLE with credit 0 and HEX7:HEX6 "01".
- Credit 95, rise sw[1] and sw[0] in the same cycle -> sum 6 rejected; credit 95; ledg[7]=1. Then rise sw[0] -> credit 96; ledg[7]=0.
- Credit 3, sel=0, rise sw[5] -> ledg[6]=1; credit 3. Rise sw[5] and sw[6] together -> cancel wins: CHANGE with change 3, sold unchanged.
- Assert reset during DISPENSE with change 7 -> next cycle: IDLE, change 0, ledg=8'b0000_1000 + sel, all hex 7'h40.
